// File: rtl/stage_execute_muldiv.sv
// Iterative multiply/divide unit with HI/LO state for the execute stage.
// Shift-add multiply (MUL_BITS per cycle) and restoring divide; results commit only at the end of FIX.
module stage_execute_muldiv #(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int MUL_STEPS = WIDTH / MUL_BITS;
  localparam int CW        = $clog2(WIDTH + 1);
  localparam logic [3:0] OP_MULT = 4'd1, OP_MULTU = 4'd2, OP_DIV = 4'd3, OP_DIVU = 4'd4,
                         OP_MADD = 4'd5, OP_MADDU = 4'd6, OP_MSUB = 4'd7, OP_MSUBU = 4'd8,
                         OP_MTHI = 4'd9, OP_MTLO  = 4'd10;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t               state;
  logic [2*WIDTH-1:0]   p, base;
  logic [WIDTH-1:0]     dvs;
  logic [CW-1:0]        cnt;
  logic                 neg_lo, neg_hi, is_div, div0, acc_add, acc_sub;

  logic                 mul_op, div_op, sgn, a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;

  always_comb begin
    mul_op = op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    div_op = op inside {OP_DIV, OP_DIVU};
    sgn    = op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
    a_neg  = sgn & in0[WIDTH-1];
    b_neg  = sgn & in1[WIDTH-1];
    a_mag  = a_neg ? -in0 : in0;
    b_mag  = b_neg ? -in1 : in1;
  end

  assign busy = (state != IDLE) || (start && (mul_op || div_op));
  assign done = (state == FIX) && !flush;

  // Multiply step: low half of p holds the unretired multiplier bits, high half the running sum.
  logic [WIDTH+MUL_BITS-1:0] partial, upper_sum;
  logic [2*WIDTH-1:0]        mul_next;
  always_comb begin
    partial = '0;
    for (int i = 0; i < MUL_BITS; i++)
      if (p[i]) partial = partial + ({{MUL_BITS{1'b0}}, dvs} << i);
    upper_sum = {{MUL_BITS{1'b0}}, p[2*WIDTH-1:WIDTH]} + partial;
  end

  generate
    if (MUL_BITS < WIDTH) begin : g_mul_shift
      assign mul_next = {upper_sum, p[WIDTH-1:MUL_BITS]};
    end else begin : g_mul_single
      assign mul_next = upper_sum;
    end
  endgenerate

  // Restoring divide step: p = {remainder, dividend/quotient shift register}.
  logic [WIDTH:0]     rem_sh, diff;
  logic               qbit;
  logic [2*WIDTH-1:0] div_next;
  always_comb begin
    rem_sh   = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    diff     = rem_sh - {1'b0, dvs};
    qbit     = !diff[WIDTH];
    div_next = {qbit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0], p[WIDTH-2:0], qbit};
  end

  logic [2*WIDTH-1:0] prod_s, mul_res, div_res, fix_res;
  logic [WIDTH-1:0]   quo, rem;
  always_comb begin
    prod_s  = neg_lo ? -p : p;
    mul_res = acc_sub ? base - prod_s : (acc_add ? base + prod_s : prod_s);
    quo     = p[WIDTH-1:0];
    rem     = p[2*WIDTH-1:WIDTH];
    div_res = div0 ? '0 : {neg_hi ? -rem : rem, neg_lo ? -quo : quo};
    fix_res = is_div ? div_res : mul_res;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      hi <= '0; lo <= '0;
      p <= '0; base <= '0; dvs <= '0; cnt <= '0;
      neg_lo <= 1'b0; neg_hi <= 1'b0; is_div <= 1'b0; div0 <= 1'b0;
      acc_add <= 1'b0; acc_sub <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start && !flush) begin
          if (op == OP_MTHI) hi <= in0;
          else if (op == OP_MTLO) lo <= in0;
          else if (mul_op) begin
            state   <= MUL;
            cnt     <= CW'(MUL_STEPS - 1);
            p       <= {{WIDTH{1'b0}}, b_mag};
            dvs     <= a_mag;
            neg_lo  <= a_neg ^ b_neg;
            is_div  <= 1'b0;
            acc_add <= op inside {OP_MADD, OP_MADDU};
            acc_sub <= op inside {OP_MSUB, OP_MSUBU};
            base    <= {hi, lo};
          end else if (div_op) begin
            state   <= DIV;
            cnt     <= CW'(WIDTH - 1);
            p       <= {{WIDTH{1'b0}}, a_mag};
            dvs     <= b_mag;
            neg_lo  <= a_neg ^ b_neg;
            neg_hi  <= a_neg;
            div0    <= (in1 == '0);
            is_div  <= 1'b1;
            acc_add <= 1'b0;
            acc_sub <= 1'b0;
          end
        end
        MUL: if (flush) state <= IDLE;
             else begin
               p <= mul_next;
               if (cnt == '0) state <= FIX;
               else cnt <= cnt - 1'b1;
             end
        DIV: if (flush) state <= IDLE;
             else begin
               p <= div_next;
               if (cnt == '0) state <= FIX;
               else cnt <= cnt - 1'b1;
             end
        FIX: begin
          if (!flush) {hi, lo} <= fix_res;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stage_execute_muldiv.sv
// Bench for stage_execute_muldiv: 32/8 instance against an arithmetic reference model, plus a 16/4 instance.
module tb_stage_execute_muldiv;
  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [3:0]  op;
  logic [31:0] in0, in1, hi, lo;
  logic        busy, done;

  logic        b_reset, b_start, b_flush;
  logic [3:0]  b_op;
  logic [15:0] b_in0, b_in1, b_hi, b_lo;
  logic        b_busy, b_done;

  int checks = 0, errors = 0;
  logic [31:0] mhi, mlo;

  always #5 clk = ~clk;

  stage_execute_muldiv #(.WIDTH(32), .MUL_BITS(8)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .in0(in0), .in1(in1),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo));

  stage_execute_muldiv #(.WIDTH(16), .MUL_BITS(4)) dut16 (
    .clk(clk), .reset(b_reset), .start(b_start), .op(b_op), .in0(b_in0), .in1(b_in1),
    .flush(b_flush), .busy(b_busy), .done(b_done), .hi(b_hi), .lo(b_lo));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural values.
  function automatic logic [63:0] md_model(input logic [3:0] o, input logic [31:0] a,
                                           input logic [31:0] b, input logic [63:0] acc);
    longint sa, sb, q, r;
    logic [63:0] pu, ps;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    pu = {32'b0, a} * {32'b0, b};
    ps = sa * sb;
    case (o)
      4'd1: return ps;
      4'd2: return pu;
      4'd3: begin
        if (b == 0) return 64'd0;
        q = sa / sb; r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      4'd4: begin
        if (b == 0) return 64'd0;
        return {a % b, a / b};
      end
      4'd5: return acc + ps;
      4'd6: return acc + pu;
      4'd7: return acc - ps;
      4'd8: return acc - pu;
      4'd9: return {a, acc[31:0]};
      4'd10: return {acc[63:32], a};
      default: return acc;
    endcase
  endfunction

  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] expv, old;
    bit iter;
    int lat, dcnt, dk;
    old  = {mhi, mlo};
    iter = (o >= 4'd1 && o <= 4'd8);
    expv = md_model(o, a, b, old);
    @(negedge clk);
    start = 1'b1; op = o; in0 = a; in1 = b;
    #1;
    chk("busy_comb", {63'd0, busy}, {63'd0, iter});
    if (!iter) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("mt_hilo", {hi, lo}, expv);
      chk("mt_busy", {63'd0, busy}, 64'd0);
      chk("mt_done", {63'd0, done}, 64'd0);
    end else begin
      lat  = (o == 4'd3 || o == 4'd4) ? 33 : 5;
      dcnt = 0;
      dk   = -1;
      for (int k = 0; k <= lat; k++) begin
        @(negedge clk);
        if (k == 0) start = 1'b0;
        #1;
        if (done) begin
          dcnt++;
          if (dk < 0) dk = k;
        end
        if (k == 0) chk("busy_run", {63'd0, busy}, 64'd1);
        if (k == lat - 1) chk("hilo_hold", {hi, lo}, old);
      end
      chk("done_count", 64'(dcnt), 64'd1);
      chk("done_cycle", 64'(dk), 64'(lat - 1));
      chk("result", {hi, lo}, expv);
      chk("busy_end", {63'd0, busy}, 64'd0);
    end
    {mhi, mlo} = expv;
  endtask

  task automatic run16(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                       input int lat, input logic [31:0] expv);
    int dk;
    dk = -1;
    @(negedge clk);
    b_start = 1'b1; b_op = o; b_in0 = a; b_in1 = b;
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      if (k == 0) b_start = 1'b0;
      #1;
      if (b_done && dk < 0) dk = k;
    end
    chk("w16_done_cycle", 64'(dk), 64'(lat - 1));
    chk("w16_result", {32'd0, b_hi, b_lo}, {32'd0, expv});
    chk("w16_busy_end", {63'd0, b_busy}, 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  ro;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; in0 = '0; in1 = '0;
    b_reset = 1'b1; b_start = 1'b0; b_flush = 1'b0; b_op = '0; b_in0 = '0; b_in1 = '0;
    mhi = '0; mlo = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; b_reset = 1'b0;
    #1;
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst16_hilo", {32'd0, b_hi, b_lo}, 64'd0);
    chk("rst16_busy", {63'd0, b_busy}, 64'd0);

    // Directed cases from the plan
    run_op(4'd1, 32'hFFFFFFFE, 32'd3);
    chk("mult_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
    run_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu_max", {hi, lo}, 64'hFFFFFFFE_00000001);
    run_op(4'd6, 32'd1, 32'd1);
    chk("maddu", {hi, lo}, 64'hFFFFFFFE_00000002);
    run_op(4'd7, 32'hFFFFFFFF, 32'd5);
    run_op(4'd3, -32'sd7, 32'd2);
    chk("div_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(4'd4, 32'd7, 32'd0);
    chk("divu_zero", {hi, lo}, 64'd0);
    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF);
    chk("div_min", {hi, lo}, 64'h00000000_80000000);
    run_op(4'd9, 32'hCAFE0001, 32'd0);
    run_op(4'd10, 32'h1234, 32'd0);

    // Flush on the 10th DIV cycle, with a simultaneous start that must be ignored
    @(negedge clk);
    start = 1'b1; op = 4'd3; in0 = 32'd100; in1 = 32'd7;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      #1;
      if (done) chk("flush_early_done", {63'd0, done}, 64'd0);
    end
    flush = 1'b1; start = 1'b1; op = 4'd1; in0 = 32'd3; in1 = 32'd3;
    #1;
    chk("flush_div_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1;
    chk("flush_div_busy", {63'd0, busy}, 64'd0);
    chk("flush_div_hilo", {hi, lo}, {mhi, mlo});
    repeat (6) @(negedge clk);
    #1;
    chk("flush_start_ignored", {63'd0, busy}, 64'd0);
    chk("flush_start_hilo", {hi, lo}, {mhi, mlo});

    // MTLO with flush high in IDLE is blocked
    @(negedge clk);
    flush = 1'b1; start = 1'b1; op = 4'd10; in0 = 32'hDEADBEEF;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1;
    chk("flush_mt_blocked", {32'd0, lo}, {32'd0, mlo});

    // Flush during FIX wins over commit
    @(negedge clk);
    start = 1'b1; op = 4'd2; in0 = 32'd3; in1 = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("fix_done_pre", {63'd0, done}, 64'd1);
    flush = 1'b1;
    #1;
    chk("fix_done_flushed", {63'd0, done}, 64'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("fix_flush_hilo", {hi, lo}, {mhi, mlo});
    chk("fix_flush_busy", {63'd0, busy}, 64'd0);

    // Randomized ops against the reference model
    for (int n = 0; n < 30; n++) begin
      ro = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = 32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op(ro, ra, rb);
    end

    // 16-bit, 4 bits per cycle
    run16(4'd1, 16'h8000, 16'h8000, 5, 32'h4000_0000);
    run16(4'd4, 16'd1000, 16'd7, 17, {16'd6, 16'd142});
    run16(4'd3, -16'sd100, 16'd7, 17, {16'hFFFE, 16'hFFF2});
    @(negedge clk);
    b_start = 1'b1; b_op = 4'd2; b_in0 = 16'hFFFF; b_in1 = 16'hFFFF;
    @(negedge clk);
    b_start = 1'b0;
    @(negedge clk);
    b_reset = 1'b1;
    @(negedge clk);
    b_reset = 1'b0;
    #1;
    chk("w16_rst_hilo", {32'd0, b_hi, b_lo}, 64'd0);
    chk("w16_rst_busy", {63'd0, b_busy}, 64'd0);
    repeat (6) @(negedge clk);
    #1;
    chk("w16_rst_after", {31'd0, b_busy, b_hi, b_lo}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stage_execute_muldiv.md
Name: stage_execute_muldiv

Overview:
- Parametrised iterative multiply/divide unit with HI/LO state, placed in the execute stage next to the ALU.
- Replaces the fixed-delay behavioural HI/LO model with genuine shift-add multiplication and restoring division.
- Adds multiply-accumulate ops, a configurable width and multiply radix, and flush-abort of in-flight ops without corrupting HI/LO.

Parameters:
- WIDTH, 32, operand and HI/LO width; even, >= 4.
- MUL_BITS, 8, multiplier bits retired per cycle; must divide WIDTH.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  op valid this cycle (E-stage instruction is a md-class op)
- op  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MADD, 6 MADDU, 7 MSUB, 8 MSUBU, 9 MTHI, 10 MTLO; others = NONE
- in0  in  WIDTH  rs operand (multiplicand/dividend, MT source)
- in1  in  WIDTH  rt operand (multiplier/divisor)
- flush  in  1  interrupt/exception request; blocks start and aborts in-flight op
- busy  out  1  stall request to hazard unit
- done  out  1  one-cycle pulse when HI/LO commit from an iterative op
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset:
  - hi = lo = 0; state IDLE; done = 0.
  - busy follows its combinational definition below.
  - A reset mid-operation discards the op.
- busy = (state != IDLE) || (start && op in 1..8). busy is combinational in start/op.
- Accept: start && state == IDLE && !flush. A start while not IDLE or with flush high is ignored; no state change.
- MTHI/MTLO: on accept, hi (resp. lo) <= in0 at that edge; no busy, no done.
- Iterative ops:
  - Operands and accumulation base {hi,lo} are latched at accept.
  - Work proceeds in shadow registers; architectural hi/lo stay unchanged until commit.
- States and transitions:
  - IDLE -> MUL (ops 1,2,5-8) or DIV (3,4).
  - MUL runs WIDTH/MUL_BITS cycles, then -> FIX.
  - DIV runs WIDTH cycles (1 quotient bit/cycle, restoring), then -> FIX.
  - FIX lasts 1 cycle: sign correction and accumulate; commits hi/lo at its end; done = 1 during FIX; -> IDLE.
- Latency L counts edges after the accept edge:
  - MUL: L = WIDTH/MUL_BITS + 1 (5 at defaults).
  - DIV: L = WIDTH + 1 (33 at defaults).
  - New hi/lo are visible and state is IDLE after edge accept+L.
  - A back-to-back start is accepted in that cycle.
- Signed ops operate on magnitudes; the sign is applied in FIX.
- Multiply arithmetic:
  - MULT/MULTU: {hi,lo} = 2*WIDTH-bit product.
  - MADD(U): {hi,lo} = {hi,lo}_latched + product, modulo 2^(2*WIDTH).
  - MSUB(U): {hi,lo} = {hi,lo}_latched - product, modulo 2^(2*WIDTH).
- Divide arithmetic:
  - lo = quotient truncated toward zero; hi = remainder with the dividend's sign.
  - Signed MIN / -1: lo = MIN, hi = 0.
  - Divisor 0: hi = lo = 0. Still takes full DIV latency.
- Flush:
  - flush high while state != IDLE: state -> IDLE at the next edge.
  - No commit and no done; hi/lo keep their pre-op values.
  - flush in the FIX cycle also aborts, i.e. flush wins over commit.
- done is registered-free and asserted only in FIX when flush is low.

Test Plan:
- MULT in0=0xFFFFFFFE (-2), in1=3 -> busy for 5 cycles; after edge 5 hi=0xFFFFFFFF, lo=0xFFFFFFFA; done pulses once.
- MULTU in0=in1=0xFFFFFFFF, then MADDU in0=in1=1 -> {hi,lo}=0xFFFFFFFE_00000001, then 0xFFFFFFFE_00000002.
- DIV in0=-7, in1=2 -> after 33 cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU 7/0 -> hi=lo=0.
- DIV in0=0x80000000, in1=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTLO 0x1234 then DIV started; flush asserted on cycle 10 of DIV -> busy drops next edge, lo=0x1234 unchanged, no done; start with flush high in the same cycle is ignored.
- Parameter sweep WIDTH=16, MUL_BITS=4: MULT 0x8000*0x8000 -> 5 cycles, hi=0x4000, lo=0; DIV latency 17; reset asserted mid-MUL -> hi=lo=0, IDLE next cycle.
